// File: rtl/zsdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: call encodings, bus widths
// and the arbiter state encoding.
package zsdram_pkg;

  localparam int SDRAM_AW = 24;
  localparam int SDRAM_DW = 16;

  localparam logic [1:0] CALL_NONE = 2'b00;
  localparam logic [1:0] CALL_RD   = 2'b01;
  localparam logic [1:0] CALL_WR   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // A client call with both bits set is treated as a write.
  function automatic logic [1:0] decode_call(input logic [1:0] call);
    if (call[1]) begin
      return CALL_WR;
    end
    if (call[0]) begin
      return CALL_RD;
    end
    return CALL_NONE;
  endfunction

endpackage

// File: rtl/zsdram_port_arbiter_if.sv
// Bundle of the two client ports and the base-controller port.
// master: the arbiter's view; slave: the clients and base controller.
interface zsdram_port_arbiter_if;
  import zsdram_pkg::*;

  logic [1:0]          c0_call;
  logic [1:0]          c1_call;
  logic [SDRAM_AW-1:0] c0_addr;
  logic [SDRAM_AW-1:0] c1_addr;
  logic [SDRAM_DW-1:0] c0_wdata;
  logic [SDRAM_DW-1:0] c1_wdata;
  logic                c0_done;
  logic                c1_done;
  logic                c0_err;
  logic                c1_err;
  logic [SDRAM_DW-1:0] c0_rdata;
  logic [SDRAM_DW-1:0] c1_rdata;
  logic [1:0]          m_call;
  logic [SDRAM_AW-1:0] m_addr;
  logic [SDRAM_DW-1:0] m_wdata;
  logic [1:0]          m_done;
  logic [SDRAM_DW-1:0] m_rdata;
  logic                busy;

  modport master (
    input  c0_call, c1_call, c0_addr, c1_addr, c0_wdata, c1_wdata,
    input  m_done, m_rdata,
    output c0_done, c1_done, c0_err, c1_err, c0_rdata, c1_rdata,
    output m_call, m_addr, m_wdata, busy
  );

  modport slave (
    output c0_call, c1_call, c0_addr, c1_addr, c0_wdata, c1_wdata,
    output m_done, m_rdata,
    input  c0_done, c1_done, c0_err, c1_err, c0_rdata, c1_rdata,
    input  m_call, m_addr, m_wdata, busy
  );

endinterface

// File: rtl/zsdram_port_arbiter_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// client that was not granted last time.
module zrr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_valid
);

  // One-hot grant from the request pair and the last winner
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/zsdram_port_arbiter.sv
// Shares one single-word SDRAM controller port between two clients:
// one transaction at a time, fair alternation, watchdog abort.
module zsdram_port_arbiter
  import zsdram_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  zsdram_port_arbiter_if.master io_bus
);

  // Watchdog fires on the ISSUE cycle where the counter would reach TIMEOUT.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_t          r_state;
  logic [15:0]         r_count;
  logic                r_last;
  logic                r_owner;
  logic                r_mask;
  logic                r_busy;
  logic [1:0]          r_op;
  logic [1:0]          r_m_call;
  logic [SDRAM_AW-1:0] r_m_addr;
  logic [SDRAM_DW-1:0] r_m_wdata;
  logic                r_c0_done;
  logic                r_c1_done;
  logic                r_c0_err;
  logic                r_c1_err;
  logic [SDRAM_DW-1:0] r_c0_rdata;
  logic [SDRAM_DW-1:0] r_c1_rdata;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_valid;
  logic                w_sel;
  logic [1:0]          w_sel_call;
  logic [SDRAM_AW-1:0] w_sel_addr;
  logic [SDRAM_DW-1:0] w_sel_wdata;
  logic                w_hit;

  // The client just served is ignored for the first IDLE cycle after RELEASE.
  assign w_req[0] = (io_bus.c0_call != CALL_NONE) && !(r_mask && !r_owner);
  assign w_req[1] = (io_bus.c1_call != CALL_NONE) && !(r_mask && r_owner);

  zrr_pick2 u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  assign w_sel       = w_gnt[1];
  assign w_sel_call  = decode_call(({2{w_gnt[0]}} & io_bus.c0_call) |
                                   ({2{w_gnt[1]}} & io_bus.c1_call));
  assign w_sel_addr  = ({SDRAM_AW{w_gnt[0]}} & io_bus.c0_addr) |
                       ({SDRAM_AW{w_gnt[1]}} & io_bus.c1_addr);
  assign w_sel_wdata = ({SDRAM_DW{w_gnt[0]}} & io_bus.c0_wdata) |
                       ({SDRAM_DW{w_gnt[1]}} & io_bus.c1_wdata);

  // Only the done bit matching the latched operation ends ISSUE.
  assign w_hit = (r_op == CALL_WR) ? io_bus.m_done[1] : io_bus.m_done[0];

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_mask     <= 1'b0;
      r_busy     <= 1'b0;
      r_op       <= CALL_NONE;
      r_m_call   <= CALL_NONE;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_c0_done  <= 1'b0;
      r_c1_done  <= 1'b0;
      r_c0_err   <= 1'b0;
      r_c1_err   <= 1'b0;
      r_c0_rdata <= '0;
      r_c1_rdata <= '0;
    end else begin
      r_c0_done <= 1'b0;
      r_c1_done <= 1'b0;
      r_c0_err  <= 1'b0;
      r_c1_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mask <= 1'b0;
          if (w_valid) begin
            r_owner   <= w_sel;
            r_last    <= w_sel;
            r_op      <= w_sel_call;
            r_m_call  <= w_sel_call;
            r_m_addr  <= w_sel_addr;
            r_m_wdata <= w_sel_wdata;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_count <= r_count + 16'd1;
          if (w_hit || (r_count == TO_LAST)) begin
            r_m_call <= CALL_NONE;
            r_state  <= ST_RELEASE;
            if (r_owner) begin
              r_c1_done <= 1'b1;
              r_c1_err  <= !w_hit;
            end else begin
              r_c0_done <= 1'b1;
              r_c0_err  <= !w_hit;
            end
            if (w_hit && (r_op == CALL_RD)) begin
              if (r_owner) begin
                r_c1_rdata <= io_bus.m_rdata;
              end else begin
                r_c0_rdata <= io_bus.m_rdata;
              end
            end
          end
        end
        ST_RELEASE: begin
          r_mask  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_m_call <= CALL_NONE;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.m_call   = r_m_call;
  assign io_bus.m_addr   = r_m_addr;
  assign io_bus.m_wdata  = r_m_wdata;
  assign io_bus.c0_done  = r_c0_done;
  assign io_bus.c1_done  = r_c1_done;
  assign io_bus.c0_err   = r_c0_err;
  assign io_bus.c1_err   = r_c1_err;
  assign io_bus.c0_rdata = r_c0_rdata;
  assign io_bus.c1_rdata = r_c1_rdata;
  assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_zsdram_port_arbiter.sv
// Self-checking bench for zsdram_port_arbiter: client drivers, a base
// controller model, and scoreboards on the issue side and the done side.
module tb_zsdram_port_arbiter;
  import zsdram_pkg::*;

  typedef struct {
    logic [1:0]  call;
    logic [23:0] addr;
    logic [15:0] wdata;
  } issueExp_t;

  typedef struct {
    bit          err;
    logic [15:0] rdata;
    bit          timeoutChk;
  } doneExp_t;

  logic clk;
  logic rst_n;

  zsdram_port_arbiter_if bus ();

  zsdram_port_arbiter #(
    .TIMEOUT (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int vectorsApplied = 0;
  int miscompares    = 0;
  int cycle          = 0;

  issueExp_t   mQ[$];
  doneExp_t    doneQ0[$];
  doneExp_t    doneQ1[$];
  logic [15:0] pushRd[2];
  logic [15:0] popRd[2];
  logic [15:0] refMem[logic [23:0]];
  logic [15:0] modelMem[logic [23:0]];

  int  latency   = 3;
  bit  respond   = 1'b1;
  bit  strayDone = 1'b0;
  int  waitCnt   = 0;
  bit  gapChk    = 1'b0;
  bit  gapArm    = 1'b0;
  int  lastMatch = -100;
  int  riseCycle = 0;
  int  doneCnt0  = 0;
  int  doneCnt1  = 0;
  logic [1:0] prevCall = 2'b00;

  // Free-running clock and a cycle counter for latency measurements
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Hard stop so a stuck design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running, required finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] defaultData(input logic [23:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] refRead(input logic [23:0] a);
    if (refMem.exists(a)) begin
      return refMem[a];
    end
    return defaultData(a);
  endfunction

  function automatic logic [15:0] modelRead(input logic [23:0] a);
    if (modelMem.exists(a)) begin
      return modelMem[a];
    end
    return defaultData(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic setClient(input int c, input logic [1:0] call, input logic [23:0] addr, input logic [15:0] wdata);
    if (c == 0) begin
      bus.c0_call  = call;
      bus.c0_addr  = addr;
      bus.c0_wdata = wdata;
    end else begin
      bus.c1_call  = call;
      bus.c1_addr  = addr;
      bus.c1_wdata = wdata;
    end
  endtask

  task automatic pushIssue(input logic [1:0] call, input logic [23:0] addr, input logic [15:0] wdata);
    issueExp_t e;
    e.call  = call;
    e.addr  = addr;
    e.wdata = wdata;
    mQ.push_back(e);
  endtask

  // One client transaction: record the expected completion, raise call,
  // hold until done, drop call the cycle after, idle one more cycle.
  task automatic applyStimulus(input int c, input logic [1:0] call, input logic [23:0] addr,
                               input logic [15:0] wdata, input bit expErr);
    doneExp_t e;
    bit seen;
    e.err        = expErr;
    e.timeoutChk = expErr;
    if (call[1]) begin
      e.rdata = pushRd[c];
      if (!expErr) begin
        refMem[addr] = wdata;
      end
    end else begin
      e.rdata   = expErr ? pushRd[c] : refRead(addr);
      pushRd[c] = e.rdata;
    end
    if (c == 0) begin
      doneQ0.push_back(e);
    end else begin
      doneQ1.push_back(e);
    end
    setClient(c, call, addr, wdata);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (c == 0) ? bus.c0_done : bus.c1_done;
    end
    if (!seen) begin
      checkOutput($sformatf("done_wait_c%0d", c), 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    setClient(c, CALL_NONE, addr, wdata);
    @(posedge clk);
    #1;
  endtask

  task automatic checkDone(input int c);
    doneExp_t e;
    bit empty;
    empty = (c == 0) ? (doneQ0.size() == 0) : (doneQ1.size() == 0);
    if (empty) begin
      checkOutput($sformatf("unexpected_done_c%0d", c), 32'd1, 32'd0);
      return;
    end
    e = (c == 0) ? doneQ0.pop_front() : doneQ1.pop_front();
    if (c == 0) begin
      doneCnt0++;
      checkOutput("c0_err", {31'd0, bus.c0_err}, {31'd0, e.err});
      checkOutput("c0_rdata", {16'd0, bus.c0_rdata}, {16'd0, e.rdata});
      checkOutput("c1_rdata_held", {16'd0, bus.c1_rdata}, {16'd0, popRd[1]});
    end else begin
      doneCnt1++;
      checkOutput("c1_err", {31'd0, bus.c1_err}, {31'd0, e.err});
      checkOutput("c1_rdata", {16'd0, bus.c1_rdata}, {16'd0, e.rdata});
      checkOutput("c0_rdata_held", {16'd0, bus.c0_rdata}, {16'd0, popRd[0]});
    end
    popRd[c] = e.rdata;
    if (e.timeoutChk) begin
      checkOutput("timeout_latency", cycle - riseCycle, 32'd16);
      checkOutput("timeout_m_call", {30'd0, bus.m_call}, 32'd0);
    end else begin
      checkOutput("done_latency", cycle - lastMatch, 32'd1);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  initial begin
    issueExp_t e;
    forever begin
      @(negedge clk);
      if (bus.m_call != 2'b00 && prevCall == 2'b00) begin
        if (mQ.size() == 0) begin
          checkOutput("unexpected_m_call", {30'd0, bus.m_call}, 32'd0);
        end else begin
          e = mQ.pop_front();
          checkOutput("m_call", {30'd0, bus.m_call}, {30'd0, e.call});
          checkOutput("m_addr", {8'd0, bus.m_addr}, {8'd0, e.addr});
          checkOutput("m_wdata", {16'd0, bus.m_wdata}, {16'd0, e.wdata});
          if (gapChk && gapArm) begin
            checkOutput("issue_gap", cycle - lastMatch, 32'd3);
          end
          gapArm = gapChk;
        end
        riseCycle = cycle;
      end
      if ((bus.m_call == CALL_WR && bus.m_done[1]) || (bus.m_call == CALL_RD && bus.m_done[0])) begin
        lastMatch = cycle;
      end
      if (bus.c0_done) begin
        checkDone(0);
      end
      if (bus.c1_done) begin
        checkDone(1);
      end
      prevCall = bus.m_call;
    end
  end

  // Base controller model: answers after a programmable latency
  initial begin
    bus.m_done  = 2'b00;
    bus.m_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      bus.m_done = 2'b00;
      if (bus.m_call != 2'b00) begin
        waitCnt++;
        if (strayDone && waitCnt == 1) begin
          bus.m_done = bus.m_call[1] ? 2'b01 : 2'b10;
        end
        if (respond && waitCnt == latency) begin
          if (bus.m_call[1]) begin
            modelMem[bus.m_addr] = bus.m_wdata;
            bus.m_done = 2'b10;
          end else begin
            bus.m_rdata = modelRead(bus.m_addr);
            bus.m_done  = 2'b01;
          end
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  initial begin
    int c0Before;
    int c1Before;
    bit sawCall;
    bit sawDone;

    rst_n     = 1'b0;
    pushRd[0] = 16'h0000;
    pushRd[1] = 16'h0000;
    popRd[0]  = 16'h0000;
    popRd[1]  = 16'h0000;
    setClient(0, CALL_NONE, 24'h0, 16'h0);
    setClient(1, CALL_NONE, 24'h0, 16'h0);

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_m_call", {30'd0, bus.m_call}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {30'd0, bus.c1_done, bus.c0_done}, 32'd0);
    checkOutput("rst_err", {30'd0, bus.c1_err, bus.c0_err}, 32'd0);
    checkOutput("rst_rdata", {bus.c1_rdata, bus.c0_rdata}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single write");
    latency = 3;
    pushIssue(CALL_WR, 24'h000010, 16'hABCD);
    applyStimulus(0, CALL_WR, 24'h000010, 16'hABCD, 1'b0);

    $display("[TB] read back");
    pushIssue(CALL_RD, 24'h000010, 16'h0000);
    applyStimulus(1, CALL_RD, 24'h000010, 16'h0000, 1'b0);

    $display("[TB] contention");
    c0Before = doneCnt0;
    c1Before = doneCnt1;
    for (int i = 0; i < 4; i++) begin
      pushIssue(CALL_WR, 24'h000100 + 24'(i), 16'h1000 + 16'(i));
      pushIssue(CALL_RD, 24'h000200 + 24'(i), 16'h0000);
    end
    gapChk = 1'b1;
    gapArm = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          applyStimulus(0, CALL_WR, 24'h000100 + 24'(i), 16'h1000 + 16'(i), 1'b0);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          applyStimulus(1, CALL_RD, 24'h000200 + 24'(i), 16'h0000, 1'b0);
        end
      end
    join
    gapChk = 1'b0;
    checkOutput("contention_c0_count", doneCnt0 - c0Before, 32'd4);
    checkOutput("contention_c1_count", doneCnt1 - c1Before, 32'd4);

    $display("[TB] timeout");
    respond = 1'b0;
    pushIssue(CALL_WR, 24'h000030, 16'h1234);
    applyStimulus(0, CALL_WR, 24'h000030, 16'h1234, 1'b1);
    respond = 1'b1;
    pushIssue(CALL_RD, 24'h000030, 16'h0000);
    applyStimulus(1, CALL_RD, 24'h000030, 16'h0000, 1'b0);

    $display("[TB] illegal call and stray done");
    latency   = 4;
    strayDone = 1'b1;
    pushIssue(CALL_WR, 24'h000040, 16'h5555);
    applyStimulus(0, 2'b11, 24'h000040, 16'h5555, 1'b0);
    strayDone = 1'b0;
    latency   = 3;
    pushIssue(CALL_RD, 24'h000040, 16'h0000);
    applyStimulus(1, CALL_RD, 24'h000040, 16'h0000, 1'b0);

    $display("[TB] reset during issue");
    latency = 20;
    pushIssue(CALL_RD, 24'h000020, 16'h0000);
    setClient(0, CALL_RD, 24'h000020, 16'h0000);
    sawCall = 1'b0;
    for (int i = 0; i < 50 && !sawCall; i++) begin
      @(negedge clk);
      sawCall = (bus.m_call == CALL_RD);
    end
    checkOutput("rst_issue_reached", {31'd0, sawCall}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_m_call", {30'd0, bus.m_call}, 32'd0);
    checkOutput("rst_async_busy", {31'd0, bus.busy}, 32'd0);
    setClient(0, CALL_NONE, 24'h0, 16'h0);
    pushRd[0] = 16'h0000;
    pushRd[1] = 16'h0000;
    popRd[0]  = 16'h0000;
    popRd[1]  = 16'h0000;
    sawDone   = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sawDone = sawDone | bus.c0_done | bus.c1_done;
    end
    checkOutput("rst_no_done", {31'd0, sawDone}, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    latency = 3;
    @(posedge clk);
    #1;
    pushIssue(CALL_WR, 24'h000050, 16'h7777);
    pushIssue(CALL_RD, 24'h000060, 16'h0000);
    gapChk = 1'b1;
    gapArm = 1'b0;
    fork
      applyStimulus(0, CALL_WR, 24'h000050, 16'h7777, 1'b0);
      applyStimulus(1, CALL_RD, 24'h000060, 16'h0000, 1'b0);
    join
    gapChk = 1'b0;

    repeat (4) @(negedge clk);
    checkOutput("issue_queue_drained", mQ.size(), 32'd0);
    checkOutput("done_queues_drained", doneQ0.size() + doneQ1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
